// File: rtl/vlsu_dmem_responder_if.sv
// Request/response bundle between the vector LSU address scheduler
// (master) and the scratchpad responder (slave).
//   ren/wen          load/store request, held by the requester through dhit
//   final_addr       element byte address
//   final_storedata  store data, element right-aligned
//   byte_ena         size code: 00 byte, 01 halfword, 10 word, 11 reserved
//   dhit             one-cycle response strobe
//   loaddata         zero-extended, right-aligned load result
//   error            request rejected, valid with dhit
//   busy             responder is servicing a request
interface vlsu_dmem_responder_if;
    logic        ren;
    logic        wen;
    logic [31:0] final_addr;
    logic [31:0] final_storedata;
    logic [1:0]  byte_ena;
    logic        dhit;
    logic [31:0] loaddata;
    logic        error;
    logic        busy;

    modport master (
        output ren, wen, final_addr, final_storedata, byte_ena,
        input  dhit, loaddata, error, busy
    );

    modport slave (
        input  ren, wen, final_addr, final_storedata, byte_ena,
        output dhit, loaddata, error, busy
    );
endinterface

// File: rtl/vlsu_dmem_responder.sv
// Fixed-latency scratchpad responder standing in for the data cache on the
// vector memory path. One request is accepted in IDLE, held in WAIT while
// the latency counter runs down, and answered with a one-cycle dhit in RESP.
// Ports:
//   CLK   rising-edge clock
//   nRST  asynchronous active-low reset
//   bus   slave side of vlsu_dmem_responder_if
// Timing: with LATENCY=L the counter is loaded with L-1 at acceptance and
// RESP is entered on the edge where it reaches zero (directly at acceptance
// when L=1), so dhit appears L cycles after the request cycle and a held
// requester gets one response every L+1 cycles.
module vlsu_dmem_responder #(
    parameter int          DEPTH_WORDS = 256,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                  CLK,
    input  logic                  nRST,
    vlsu_dmem_responder_if.slave  bus
);
    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic        accept, go_resp;

    // request as presented on the bus this cycle
    logic [31:0] req_off;
    logic        req_err;

    // request as latched at acceptance
    logic          q_ren, q_wen, q_err;
    logic [1:0]    q_size, q_lane;
    logic [AW-1:0] q_idx;
    logic [31:0]   q_data;

    // acceptance and response coincide when LATENCY=1, so the commit path
    // takes the live bus in IDLE and the latched copy otherwise
    logic          sel_ren, sel_wen, sel_err;
    logic [1:0]    sel_size, sel_lane;
    logic [AW-1:0] sel_idx;
    logic [31:0]   sel_data;

    logic [3:0]  wmask;
    logic [31:0] wdata, rd_word, rd_shift, rd_val;
    logic        error_q;
    logic [31:0] ld_q;

    logic [31:0] mem [DEPTH_WORDS];

    // unsigned subtraction: addresses below base wrap high and fail the range check
    assign req_off = bus.final_addr - BASE_ADDR;
    assign req_err = (bus.ren & bus.wen)
                   | (bus.byte_ena == 2'b11)
                   | ((bus.byte_ena == 2'b01) & bus.final_addr[0])
                   | ((bus.byte_ena == 2'b10) & (bus.final_addr[1:0] != 2'b00))
                   | (req_off >= SPAN);

    always_comb begin
        if (state == IDLE) begin
            sel_ren  = bus.ren;
            sel_wen  = bus.wen;
            sel_err  = req_err;
            sel_size = bus.byte_ena;
            sel_lane = bus.final_addr[1:0];
            sel_idx  = req_off[AW+1:2];
            sel_data = bus.final_storedata;
        end else begin
            sel_ren  = q_ren;
            sel_wen  = q_wen;
            sel_err  = q_err;
            sel_size = q_size;
            sel_lane = q_lane;
            sel_idx  = q_idx;
            sel_data = q_data;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        go_resp = 1'b0;
        case (state)
            IDLE: begin
                if (bus.ren | bus.wen) begin
                    accept = 1'b1;
                    cnt_n  = CNT_INIT;
                    if (LATENCY > 1) begin
                        state_n = WAIT;
                    end else begin
                        state_n = RESP;
                        go_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                cnt_n = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    state_n = RESP;
                    go_resp = 1'b1;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // lane steering for stores and right-alignment for loads
    always_comb begin
        wmask = 4'b0000;
        wdata = sel_data;
        case (sel_size)
            2'b00: begin
                wmask = 4'b0001 << sel_lane;
                wdata = {4{sel_data[7:0]}};
            end
            2'b01: begin
                wmask = sel_lane[1] ? 4'b1100 : 4'b0011;
                wdata = {2{sel_data[15:0]}};
            end
            2'b10:   wmask = 4'b1111;
            default: wmask = 4'b0000;
        endcase
        rd_word  = mem[sel_idx];
        rd_shift = rd_word >> {sel_lane, 3'b000};
        case (sel_size)
            2'b00:   rd_val = {24'd0, rd_shift[7:0]};
            2'b01:   rd_val = {16'd0, rd_shift[15:0]};
            default: rd_val = rd_word;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            error_q <= 1'b0;
            ld_q    <= 32'd0;
            q_ren   <= 1'b0;
            q_wen   <= 1'b0;
            q_err   <= 1'b0;
            q_size  <= 2'b00;
            q_lane  <= 2'b00;
            q_idx   <= '0;
            q_data  <= 32'd0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            error_q <= go_resp & sel_err;
            if (accept) begin
                q_ren  <= bus.ren;
                q_wen  <= bus.wen;
                q_err  <= req_err;
                q_size <= bus.byte_ena;
                q_lane <= bus.final_addr[1:0];
                q_idx  <= req_off[AW+1:2];
                q_data <= bus.final_storedata;
            end
            if (go_resp && sel_ren && !sel_err)
                ld_q <= rd_val;
        end
    end

    // scratchpad is not reset; the nRST term keeps an edge seen while reset
    // is held from committing a store
    always_ff @(posedge CLK) begin
        if (nRST && go_resp && sel_wen && !sel_err) begin
            for (int b = 0; b < 4; b++)
                if (wmask[b]) mem[sel_idx][b*8 +: 8] <= wdata[b*8 +: 8];
        end
    end

    assign bus.dhit     = (state == RESP);
    assign bus.error    = error_q;
    assign bus.loaddata = ld_q;
    assign bus.busy     = (state != IDLE);
endmodule

// File: tb/tb_vlsu_dmem_responder.sv
module tb_vlsu_dmem_responder;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_R = 2'b11;

    logic CLK = 1'b0;
    logic rst1 = 1'b0, rst2 = 1'b0, rst3 = 1'b0;
    always #5 CLK = ~CLK;

    logic        t_ren = 1'b0, t_wen = 1'b0;
    logic [31:0] t_addr = 32'd0, t_data = 32'd0;
    logic [1:0]  t_size = 2'b00;
    int          sel = 2;

    int n_chk = 0;
    int n_fail = 0;

    vlsu_dmem_responder_if if1 ();
    vlsu_dmem_responder_if if2 ();
    vlsu_dmem_responder_if if3 ();

    assign if1.ren = t_ren & (sel == 1);
    assign if1.wen = t_wen & (sel == 1);
    assign if2.ren = t_ren & (sel == 2);
    assign if2.wen = t_wen & (sel == 2);
    assign if3.ren = t_ren & (sel == 3);
    assign if3.wen = t_wen & (sel == 3);
    assign if1.final_addr = t_addr;
    assign if2.final_addr = t_addr;
    assign if3.final_addr = t_addr;
    assign if1.final_storedata = t_data;
    assign if2.final_storedata = t_data;
    assign if3.final_storedata = t_data;
    assign if1.byte_ena = t_size;
    assign if2.byte_ena = t_size;
    assign if3.byte_ena = t_size;

    vlsu_dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1), .BASE_ADDR(BASE)) u_l1 (.CLK(CLK), .nRST(rst1), .bus(if1));
    vlsu_dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2), .BASE_ADDR(BASE)) u_l2 (.CLK(CLK), .nRST(rst2), .bus(if2));
    vlsu_dmem_responder #(.DEPTH_WORDS(256), .LATENCY(3), .BASE_ADDR(BASE)) u_l3 (.CLK(CLK), .nRST(rst3), .bus(if3));

    logic        o_dhit, o_err, o_busy;
    logic [31:0] o_ld;
    always_comb begin
        o_dhit = if2.dhit; o_err = if2.error; o_busy = if2.busy; o_ld = if2.loaddata;
        if (sel == 1) begin
            o_dhit = if1.dhit; o_err = if1.error; o_busy = if1.busy; o_ld = if1.loaddata;
        end else if (sel == 3) begin
            o_dhit = if3.dhit; o_err = if3.error; o_busy = if3.busy; o_ld = if3.loaddata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One held request against the selected DUT, starting at a negedge.
    // Sample k is the negedge after edge k-1; dhit is due at k == latency.
    task automatic xact(input string tag, input logic r, input logic w, input logic [1:0] sz,
                        input logic [31:0] off, input logic [31:0] d,
                        input logic exp_err, input logic [31:0] exp_ld, input bit scramble);
        int lat, pulses, busy_n, stray_err;
        lat = (sel == 1) ? 1 : (sel == 2) ? 2 : 3;
        pulses = 0; busy_n = 0; stray_err = 0;
        t_ren = r; t_wen = w; t_size = sz; t_addr = BASE + off; t_data = d;
        for (int k = 1; k <= lat + 2; k++) begin
            @(negedge CLK);
            pulses += int'(o_dhit);
            busy_n += int'(o_busy);
            if (!o_dhit && o_err) stray_err++;
            if (k == lat) begin
                chk({tag, " dhit"}, 32'(o_dhit), 32'd1);
                chk({tag, " error"}, 32'(o_err), 32'(exp_err));
                chk({tag, " loaddata"}, o_ld, exp_ld);
                t_ren = 1'b0; t_wen = 1'b0;
            end
            if (scramble && k == 1) begin
                t_addr = t_addr ^ 32'h4;
                t_data = ~t_data;
            end
        end
        chk({tag, " pulses"}, 32'(pulses), 32'd1);
        chk({tag, " busy cycles"}, 32'(busy_n), 32'(lat));
        chk({tag, " stray error"}, 32'(stray_err), 32'd0);
    endtask

    initial begin
        int pulses, consec, bad_err;
        logic prev;
        repeat (2) @(negedge CLK);
        for (int s = 1; s <= 3; s++) begin
            sel = s;
            #1;
            chk($sformatf("reset dut%0d dhit", s), 32'(o_dhit), 32'd0);
            chk($sformatf("reset dut%0d error", s), 32'(o_err), 32'd0);
            chk($sformatf("reset dut%0d busy", s), 32'(o_busy), 32'd0);
            chk($sformatf("reset dut%0d loaddata", s), o_ld, 32'd0);
        end
        rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
        @(negedge CLK);

        // ---- LATENCY=2: basic word, byte/halfword lanes, errors ----
        sel = 2;
        xact("st_w10",   0, 1, SZ_W, 32'h10, 32'hDEADBEEF, 0, 32'h0000_0000, 0);
        xact("ld_w10",   1, 0, SZ_W, 32'h10, 32'h0,        0, 32'hDEADBEEF, 0);
        xact("st_b20",   0, 1, SZ_B, 32'h20, 32'h11,       0, 32'hDEADBEEF, 0);
        xact("st_b21",   0, 1, SZ_B, 32'h21, 32'h22,       0, 32'hDEADBEEF, 0);
        xact("st_b22",   0, 1, SZ_B, 32'h22, 32'h33,       0, 32'hDEADBEEF, 0);
        xact("st_b23",   0, 1, SZ_B, 32'h23, 32'h44,       0, 32'hDEADBEEF, 0);
        xact("ld_h22",   1, 0, SZ_H, 32'h22, 32'h0,        0, 32'h0000_4433, 0);
        xact("ld_b21",   1, 0, SZ_B, 32'h21, 32'h0,        0, 32'h0000_0022, 0);
        xact("st_h22",   0, 1, SZ_H, 32'h22, 32'h1234ABCD, 0, 32'h0000_0022, 0);
        xact("st_b23b",  0, 1, SZ_B, 32'h23, 32'hFFFFFF55, 0, 32'h0000_0022, 0);
        xact("ld_w20",   1, 0, SZ_W, 32'h20, 32'h0,        0, 32'h55CD2211, 0);
        xact("st_w00",   0, 1, SZ_W, 32'h00, 32'h01020304, 0, 32'h55CD2211, 0);
        xact("st_w3fc",  0, 1, SZ_W, 32'h3FC, 32'h5A5A5A5A, 0, 32'h55CD2211, 0);
        xact("err_h03",  1, 0, SZ_H, 32'h03, 32'h0,        1, 32'h55CD2211, 0);
        xact("err_w02",  0, 1, SZ_W, 32'h02, 32'h99999999, 1, 32'h55CD2211, 0);
        xact("err_szld", 1, 0, SZ_R, 32'h00, 32'h0,        1, 32'h55CD2211, 0);
        xact("err_szst", 0, 1, SZ_R, 32'h00, 32'hFFFFFFFF, 1, 32'h55CD2211, 0);
        xact("err_rw",   1, 1, SZ_W, 32'h00, 32'hEEEEEEEE, 1, 32'h55CD2211, 0);
        xact("err_top",  0, 1, SZ_W, 32'h400, 32'h77777777, 1, 32'h55CD2211, 0);
        xact("err_blw",  0, 1, SZ_W, 32'hFFFF_FFFC, 32'h66666666, 1, 32'h55CD2211, 0);
        xact("rb_w00",   1, 0, SZ_W, 32'h00, 32'h0,        0, 32'h01020304, 0);
        xact("rb_w3fc",  1, 0, SZ_W, 32'h3FC, 32'h0,       0, 32'h5A5A5A5A, 0);

        // ---- LATENCY=1: four back-to-back held stores ----
        sel = 1;
        pulses = 0; consec = 0; bad_err = 0; prev = 1'b0;
        t_ren = 1'b0; t_wen = 1'b1; t_size = SZ_W; t_addr = BASE + 32'h40; t_data = 32'h0BADF00D;
        for (int k = 1; k <= 10; k++) begin
            @(negedge CLK);
            if (o_dhit && prev) consec++;
            if (o_dhit && o_err) bad_err++;
            pulses += int'(o_dhit);
            prev = o_dhit;
            if (k == 7) t_wen = 1'b0;
        end
        chk("b2b pulses", 32'(pulses), 32'd4);
        chk("b2b consecutive", 32'(consec), 32'd0);
        chk("b2b error", 32'(bad_err), 32'd0);
        xact("l1_ld_w40", 1, 0, SZ_W, 32'h40, 32'h0,  0, 32'h0BADF00D, 0);
        xact("l1_st_b41", 0, 1, SZ_B, 32'h41, 32'h77, 0, 32'h0BADF00D, 0);
        xact("l1_ld_w40b", 1, 0, SZ_W, 32'h40, 32'h0, 0, 32'h0BAD770D, 0);

        // ---- LATENCY=3: inputs changed during WAIT, then reset abort ----
        sel = 3;
        xact("l3_st_w84", 0, 1, SZ_W, 32'h84, 32'h12345678, 0, 32'h0, 0);
        xact("l3_st_scr", 0, 1, SZ_W, 32'h80, 32'hCAFEF00D, 0, 32'h0, 1);
        xact("l3_ld_w80", 1, 0, SZ_W, 32'h80, 32'h0, 0, 32'hCAFEF00D, 0);
        xact("l3_ld_w84", 1, 0, SZ_W, 32'h84, 32'h0, 0, 32'h12345678, 0);
        xact("l3_ld_scr", 1, 0, SZ_W, 32'h80, 32'h0, 0, 32'hCAFEF00D, 1);
        xact("l3_st_w90", 0, 1, SZ_W, 32'h90, 32'h11111111, 0, 32'hCAFEF00D, 0);

        t_ren = 1'b0; t_wen = 1'b1; t_size = SZ_W; t_addr = BASE + 32'h90; t_data = 32'h22222222;
        @(negedge CLK);
        chk("abort busy before", 32'(o_busy), 32'd1);
        rst3 = 1'b0;
        #1;
        chk("abort busy", 32'(o_busy), 32'd0);
        chk("abort dhit", 32'(o_dhit), 32'd0);
        chk("abort loaddata", o_ld, 32'd0);
        t_wen = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        rst3 = 1'b1;
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            pulses += int'(o_dhit);
        end
        chk("abort no dhit", 32'(pulses), 32'd0);
        xact("l3_rb_w90", 1, 0, SZ_W, 32'h90, 32'h0, 0, 32'h11111111, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
